muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 41 ++++
 rtl/muldiv_unit.sv | 209 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Purpose  : Shared encodings for the HI/LO multiply/divide unit: operation
//            codes, HI/LO read selects, default busy latencies, FSM state
//            codes and the latched-request record.
// Config   : MULDIV_DIV_EN (define on the command line) enables DIVU/DIV in
//            muldiv_unit; when undefined, divide starts are ignored and no
//            divider is built.
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    // mul_op encodings
    localparam logic [1:0] C_OP_MULTU = 2'b00;
    localparam logic [1:0] C_OP_MULT  = 2'b01;
    localparam logic [1:0] C_OP_DIVU  = 2'b10;
    localparam logic [1:0] C_OP_DIV   = 2'b11;

    // mfhilo_sel encodings (2'b11 reads as zero as well)
    localparam logic [1:0] C_SEL_ZERO = 2'b00;
    localparam logic [1:0] C_SEL_LO   = 2'b01;
    localparam logic [1:0] C_SEL_HI   = 2'b10;

    // Default busy latencies
    localparam int C_DEF_MULT_CYCLES = 5;
    localparam int C_DEF_DIV_CYCLES  = 10;

    // FSM state codes
    localparam logic [0:0] C_ST_IDLE = 1'b0;
    localparam logic [0:0] C_ST_BUSY = 1'b1;

    // Operands captured on an accepted start
    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } muldiv_req_t;

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Multi-cycle MIPS-style HI/LO multiply/divide unit. An accepted
//            start latches the operands and holds busy for MULT_CYCLES or
//            DIV_CYCLES cycles; the result is registered into HI/LO on the
//            final busy edge only. MTHI/MTLO writes are accepted in IDLE.
// Ports    : clk        - rising-edge clock
//            reset      - synchronous active-high reset
//            start      - launch operation mul_op
//            mul_op     - 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//            mthilo_we  - write a into HI/LO (IDLE only, start wins)
//            mthilo_sel - write target: 0 LO, 1 HI
//            mfhilo_sel - read select: 01 LO, 10 HI, otherwise zero
//            a, b       - rs / rt operands
//            busy       - registered, operation in progress
//            hilo_out   - combinational read of the selected register
// Config   : MULDIV_DIV_EN - when defined, DIVU/DIV are supported; when
//            undefined, a start with mul_op[1]==1 is ignored and no divider
//            logic is present.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int MULT_CYCLES = C_DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = C_DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  mul_op,
    input  logic        mthilo_we,
    input  logic        mthilo_sel,
    input  logic [1:0]  mfhilo_sel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hilo_out
);

    localparam int C_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int C_CNT_W      = $clog2(C_MAX_CYCLES + 1);

    localparam logic [C_CNT_W-1:0] C_MULT_LOAD = C_CNT_W'(MULT_CYCLES);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE   = C_CNT_W'(1);
`ifdef MULDIV_DIV_EN
    localparam logic [C_CNT_W-1:0] C_DIV_LOAD  = C_CNT_W'(DIV_CYCLES);
`endif

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]         state_q, state_d;
    logic               busy_q, busy_d;
    logic [C_CNT_W-1:0] cnt_q, cnt_d;
    muldiv_req_t        req_q, req_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    // ------------------------------------------------------------------------
    // Start qualification: without the divider, divide starts are dropped and
    // the cycle behaves as if start were low.
    // ------------------------------------------------------------------------
    logic w_start_ok;
    logic w_accept;

`ifdef MULDIV_DIV_EN
    assign w_start_ok = start;
`else
    assign w_start_ok = start & ~mul_op[1];
`endif
    assign w_accept = (state_q == C_ST_IDLE) && w_start_ok;

    // ------------------------------------------------------------------------
    // Multiplier: the low 64 bits of a 64x64 product equal the signed product
    // once both operands are sign-extended, so one multiplier covers both.
    // ------------------------------------------------------------------------
    logic [63:0] w_mul_a;
    logic [63:0] w_mul_b;
    logic [63:0] w_prod;

    assign w_mul_a = {{32{req_q.op[0] & req_q.a[31]}}, req_q.a};
    assign w_mul_b = {{32{req_q.op[0] & req_q.b[31]}}, req_q.b};
    assign w_prod  = w_mul_a * w_mul_b;

`ifdef MULDIV_DIV_EN
    // ------------------------------------------------------------------------
    // Divider: divide magnitudes unsigned, then restore signs. This keeps
    // INT_MIN / -1 well defined (quotient wraps to 0x80000000, remainder 0).
    // ------------------------------------------------------------------------
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic        w_div_by_zero;
    logic [31:0] w_divisor;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_a_neg       = req_q.op[0] & req_q.a[31];
    assign w_b_neg       = req_q.op[0] & req_q.b[31];
    assign w_a_mag       = w_a_neg ? (~req_q.a + 32'd1) : req_q.a;
    assign w_b_mag       = w_b_neg ? (~req_q.b + 32'd1) : req_q.b;
    assign w_div_by_zero = (req_q.b == 32'd0);
    // Substitute divisor only keeps the arithmetic defined; the result is
    // discarded for a zero divisor.
    assign w_divisor     = w_div_by_zero ? 32'd1 : w_b_mag;
    assign w_q_mag       = w_a_mag / w_divisor;
    assign w_r_mag       = w_a_mag % w_divisor;
    assign w_quot        = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_rem         = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;
`endif

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= C_ST_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            req_q   <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            C_ST_IDLE: begin
                if (w_accept) begin
                    // A same-cycle MTHI/MTLO is dropped in favour of start.
                    state_d = C_ST_BUSY;
                    req_d   = '{op: mul_op, a: a, b: b};
`ifdef MULDIV_DIV_EN
                    cnt_d   = mul_op[1] ? C_DIV_LOAD : C_MULT_LOAD;
`else
                    cnt_d   = C_MULT_LOAD;
`endif
                end else if (mthilo_we) begin
                    if (mthilo_sel) begin
                        hi_d = a;
                    end else begin
                        lo_d = a;
                    end
                end
            end

            C_ST_BUSY: begin
                if (cnt_q == C_CNT_ONE) begin
                    // Final busy edge: the only point HI/LO change.
                    state_d = C_ST_IDLE;
                    cnt_d   = '0;
                    if (req_q.op[1] == 1'b0) begin
                        hi_d = w_prod[63:32];
                        lo_d = w_prod[31:0];
                    end
`ifdef MULDIV_DIV_EN
                    else if (!w_div_by_zero) begin
                        lo_d = w_quot;
                        hi_d = w_rem;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - C_CNT_ONE;
                end
            end

            default: begin
                state_d = C_ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------------
    always_comb begin
        busy_d = (state_d == C_ST_BUSY);
        busy   = busy_q;
        case (mfhilo_sel)
            C_SEL_LO: hilo_out = lo_q;
            C_SEL_HI: hilo_out = hi_q;
            default:  hilo_out = 32'd0;
        endcase
    end

endmodule : muldiv_unit
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Self-checking bench for muldiv_unit. Directed cases plus random
//            operations compared against a 64-bit arithmetic reference model
//            of HI/LO. Divide expectations follow MULDIV_DIV_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    localparam int MC = 5;
    localparam int DC = 10;
`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  mul_op;
    logic        mthilo_we;
    logic        mthilo_sel;
    logic [1:0]  mfhilo_sel;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hilo_out;

    int          tests  = 0;
    int          failed = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    muldiv_unit #(
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mul_op     (mul_op),
        .mthilo_we  (mthilo_we),
        .mthilo_sel (mthilo_sel),
        .mfhilo_sel (mfhilo_sel),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .hilo_out   (hilo_out)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic read_sel(input logic [1:0] sel, output logic [31:0] v);
        mfhilo_sel = sel;
        #1;
        v = hilo_out;
    endtask

    task automatic check_regs(input string tag);
        logic [31:0] v;
        read_sel(2'b10, v);
        check({tag, "_hi"}, v, m_hi);
        read_sel(2'b01, v);
        check({tag, "_lo"}, v, m_lo);
    endtask

    // Reference model: HI/LO as the architectural results of each operation.
    task automatic model_exec(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      sq;
        longint      sr;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (op)
            2'b00: begin
                p = 64'(x) * 64'(y);
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            2'b01: begin
                sq = sx * sy;
                p = 64'(sq);
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            2'b10: begin
                if (y != 32'd0) begin
                    m_lo = x / y;
                    m_hi = x % y;
                end
            end
            default: begin
                if (y != 32'd0) begin
                    sq = sx / sy;
                    sr = sx % sy;
                    p = 64'(sq);
                    m_lo = p[31:0];
                    p = 64'(sr);
                    m_hi = p[31:0];
                end
            end
        endcase
    endtask

    // Issue one operation, optionally with a same-cycle MTHI/MTLO, measure the
    // busy window (poking junk while busy), then compare HI/LO.
    task automatic do_op(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic mtwe, input logic mtsel, input string tag);
        bit          acc;
        int          n;
        int          cnt;
        logic [31:0] v;
        logic [31:0] hold_lo;
        acc = !op[1] || DIV_EN;
        n   = acc ? (op[1] ? DC : MC) : 0;
        @(negedge clk);
        start = 1'b1; mul_op = op; a = x; b = y; mthilo_we = mtwe; mthilo_sel = mtsel;
        hold_lo = m_lo;
        if (!acc && mtwe) begin
            if (mtsel) m_hi = x; else m_lo = x;
        end
        @(negedge clk);
        start = 1'b0; mthilo_we = 1'b0; a = $urandom; b = $urandom;
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            cnt++;
            if (cnt == 2) begin
                read_sel(2'b01, v);
                check({tag, "_lo_hold"}, v, hold_lo);
            end
            start      = 1'($urandom_range(1, 0));
            mthilo_we  = 1'($urandom_range(1, 0));
            mthilo_sel = 1'($urandom_range(1, 0));
            mul_op     = 2'($urandom_range(3, 0));
            a          = $urandom;
            @(negedge clk);
        end
        start = 1'b0; mthilo_we = 1'b0;
        check({tag, "_busy_len"}, 32'(cnt), 32'(n));
        if (acc) model_exec(op, x, y);
        check_regs(tag);
    endtask

    // MTHI/MTLO in IDLE; the same-cycle read must still show the old value.
    task automatic mt_write(input logic sel, input logic [31:0] val, input string tag);
        logic [31:0] v;
        @(negedge clk);
        mthilo_we = 1'b1; mthilo_sel = sel; a = val;
        read_sel(sel ? 2'b10 : 2'b01, v);
        check({tag, "_nobypass"}, v, sel ? m_hi : m_lo);
        @(negedge clk);
        mthilo_we = 1'b0;
        if (sel) m_hi = val; else m_lo = val;
        check_regs(tag);
    endtask

    initial begin
        logic [31:0] v;
        logic [1:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic        mtwe;

        reset = 1'b1; start = 1'b0; mul_op = 2'b00; mthilo_we = 1'b0;
        mthilo_sel = 1'b0; mfhilo_sel = 2'b00; a = 32'd0; b = 32'd0;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check_regs("rst");
        reset = 1'b0;

        // MTHI then read
        mt_write(1'b1, 32'h12345678, "mthi");
        read_sel(2'b00, v);
        check("sel_zero", v, 32'd0);
        mt_write(1'b0, 32'hCAFEF00D, "mtlo");

        // Directed arithmetic
        do_op(2'b00, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0, "multu_max");
        do_op(2'b01, 32'hFFFFFFFD, 32'd4, 1'b0, 1'b0, "mult_neg");
        do_op(2'b00, 32'd3, 32'd5, 1'b1, 1'b0, "start_wins");
        do_op(2'b01, 32'h80000000, 32'h80000000, 1'b0, 1'b0, "mult_min");
        do_op(2'b11, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, "div_neg7");
        mt_write(1'b1, 32'h11, "pre_hi");
        mt_write(1'b0, 32'h22, "pre_lo");
        do_op(2'b10, 32'd100, 32'd0, 1'b0, 1'b0, "divu_zero");
        do_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, "div_ovf");
        do_op(2'b11, 32'd7, 32'hFFFFFFFE, 1'b0, 1'b0, "div_negdiv");
        do_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, "divu_big");

        // Random operations
        for (int i = 0; i < 30; i++) begin
            op = 2'($urandom_range(3, 0));
            x  = $urandom;
            y  = $urandom;
            case ($urandom_range(3, 0))
                0: y = 32'd0;
                1: y = 32'($urandom_range(15, 0));
                2: x = -32'($urandom_range(100, 0));
                default: ;
            endcase
            mtwe = 1'($urandom_range(1, 0));
            if (op[1] && !DIV_EN) mtwe = 1'b0;
            do_op(op, x, y, mtwe, 1'($urandom_range(1, 0)), $sformatf("rnd%0d", i));
            if ($urandom_range(2, 0) == 0)
                mt_write(1'($urandom_range(1, 0)), $urandom, $sformatf("rmt%0d", i));
        end

        // Reset beats start and MTLO in the same cycle
        @(negedge clk);
        reset = 1'b1; start = 1'b1; mul_op = 2'b00; a = 32'd7; b = 32'd3;
        mthilo_we = 1'b1; mthilo_sel = 1'b0;
        @(negedge clk);
        reset = 1'b0; start = 1'b0; mthilo_we = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        check("rst_start_busy", 32'(busy), 32'd0);
        check_regs("rst_start");

        // Reset in the third busy cycle of a MULT aborts it
        mt_write(1'b1, 32'hAAAA5555, "pre_abort");
        @(negedge clk);
        start = 1'b1; mul_op = 2'b01; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        check("abort_busy1", 32'(busy), 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        check("abort_busy", 32'(busy), 32'd0);
        check_regs("abort");
        repeat (8) @(negedge clk);
        check("abort_late_busy", 32'(busy), 32'd0);
        check_regs("abort_late");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_muldiv_unit
`default_nettype wire
